// File: rtl/scan_seq_ctrl_pkg.sv
// Shared definitions for the scan_seq_ctrl scan-chain sequencer.
// The state encodings are exposed as localparams so that observers outside
// the RTL can identify FSM states without depending on enum literal names.
package scan_seq_pkg;

    localparam int SCAN_SEQ_STATES  = 5;
    localparam int SCAN_SEQ_STATE_W = 3;

    localparam logic [SCAN_SEQ_STATE_W-1:0] SCAN_SEQ_ENC_IDLE      = 3'd0;
    localparam logic [SCAN_SEQ_STATE_W-1:0] SCAN_SEQ_ENC_SHIFT_IN  = 3'd1;
    localparam logic [SCAN_SEQ_STATE_W-1:0] SCAN_SEQ_ENC_CAPTURE   = 3'd2;
    localparam logic [SCAN_SEQ_STATE_W-1:0] SCAN_SEQ_ENC_SHIFT_OUT = 3'd3;
    localparam logic [SCAN_SEQ_STATE_W-1:0] SCAN_SEQ_ENC_DONE      = 3'd4;

    typedef enum logic [SCAN_SEQ_STATE_W-1:0] {
        IDLE      = SCAN_SEQ_ENC_IDLE,
        SHIFT_IN  = SCAN_SEQ_ENC_SHIFT_IN,
        CAPTURE   = SCAN_SEQ_ENC_CAPTURE,
        SHIFT_OUT = SCAN_SEQ_ENC_SHIFT_OUT,
        DONE      = SCAN_SEQ_ENC_DONE
    } scan_seq_state_t;

    // Cycles from the start-sampling edge to the cycle in which done is high.
    function automatic int unsigned scan_seq_latency(input int unsigned chain_len);
        return 2 * chain_len + 2;
    endfunction

endpackage

// File: rtl/scan_seq_ctrl_if.sv
// Handshake and scan-pin bundle between the test-access side (master) and
// the scan_seq_ctrl sequencer (slave).
interface scan_seq_ctrl_if #(
    parameter int CHAIN_LEN = 8
);
    logic                 start;
    logic [CHAIN_LEN-1:0] pattern_in;
    logic [CHAIN_LEN-1:0] expect_in;
    logic                 scan_out;
    logic                 scan_en;
    logic                 scan_in;
    logic                 busy;
    logic                 done;
    logic [CHAIN_LEN-1:0] response_out;
    logic                 pass;

    modport master (
        output start, pattern_in, expect_in, scan_out,
        input  scan_en, scan_in, busy, done, response_out, pass
    );

    modport slave (
        input  start, pattern_in, expect_in, scan_out,
        output scan_en, scan_in, busy, done, response_out, pass
    );
endinterface

// File: rtl/scan_seq_ctrl_shift_cnt.sv
// Loadable down-counter shared by the shift-in and shift-out phases.
// o_tc flags a count of zero; the count saturates there.
module scan_shift_cnt #(
    parameter int CNT_W = 3
) (
    input  logic             clock,
    input  logic             reset_l,
    input  logic             i_load,
    input  logic             i_dec,
    input  logic [CNT_W-1:0] i_load_val,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_tc
);
    logic [CNT_W-1:0] r_cnt;

    // Load has priority over decrement; hold at zero.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == '0);
endmodule

// File: rtl/scan_seq_ctrl.sv
// scan_seq_ctrl: loads one pattern into a mux-D scan chain, issues one
// capture cycle, then unloads the response. Optional comparison against an
// expected vector is enabled by defining SCAN_SEQ_CMP_EN; without it pass
// reads 1 outside reset and expect_in is ignored.
module scan_seq_ctrl
    import scan_seq_pkg::*;
#(
    parameter int CHAIN_LEN = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN)
) (
    input  logic             clock,
    input  logic             reset_l,
    scan_seq_ctrl_if.slave   bus
);
    scan_seq_state_t      r_state;
    logic [CHAIN_LEN-1:0] r_pattern;
    logic [CHAIN_LEN-1:0] r_resp_sh;
    logic [CHAIN_LEN-1:0] r_response_out;
    logic                 r_scan_en;
    logic                 r_scan_in;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_pass;

    logic [CNT_W-1:0]     w_cnt;
    logic                 w_tc;
    logic                 w_cnt_load;
    logic                 w_cnt_dec;
    logic [CHAIN_LEN-1:0] w_resp_next;

`ifdef SCAN_SEQ_CMP_EN
    logic [CHAIN_LEN-1:0] r_expect;
`else
    logic                 w_unused_expect;
    assign w_unused_expect = ^bus.expect_in;
`endif

    // Counter loads at accept and again at capture; it counts down in both shift phases.
    assign w_cnt_load = ((r_state == IDLE) && bus.start) || (r_state == CAPTURE);
    assign w_cnt_dec  = ((r_state == SHIFT_IN) || (r_state == SHIFT_OUT)) && !w_tc;

    scan_shift_cnt #(.CNT_W(CNT_W)) u_shift_cnt (
        .clock      (clock),
        .reset_l    (reset_l),
        .i_load     (w_cnt_load),
        .i_dec      (w_cnt_dec),
        .i_load_val (CNT_W'(CHAIN_LEN - 1)),
        .o_cnt      (w_cnt),
        .o_tc       (w_tc)
    );

    // Response including the bit sampled at this edge, so the final bit is
    // visible to response_out and pass in the same cycle done rises.
    always_comb begin
        // NOTE: assign a full default first so no path leaves the variable unassigned (no latch).
        w_resp_next        = r_resp_sh;
        w_resp_next[w_cnt] = bus.scan_out;
    end

    // Sequencer FSM; every output is a flop so SE/SI never see start combinationally.
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            // NOTE: datapath registers are reset as well, so response_out reads 0 after any reset.
            r_state        <= IDLE;
            r_pattern      <= '0;
            r_resp_sh      <= '0;
            r_response_out <= '0;
            r_scan_en      <= 1'b0;
            r_scan_in      <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_pass         <= 1'b0;
`ifdef SCAN_SEQ_CMP_EN
            r_expect       <= '0;
`endif
        end else begin
            r_done <= 1'b0;
`ifndef SCAN_SEQ_CMP_EN
            r_pass <= 1'b1;
`endif
            case (r_state)
                IDLE: begin
                    r_scan_en <= 1'b0;
                    r_scan_in <= 1'b0;
                    if (bus.start) begin
                        r_pattern <= bus.pattern_in;
`ifdef SCAN_SEQ_CMP_EN
                        r_expect  <= bus.expect_in;
`endif
                        r_scan_en <= 1'b1;
                        r_scan_in <= bus.pattern_in[CHAIN_LEN-1];
                        r_busy    <= 1'b1;
                        r_state   <= SHIFT_IN;
                    end
                end
                SHIFT_IN: begin
                    if (w_tc) begin
                        r_scan_en <= 1'b0;
                        r_scan_in <= 1'b0;
                        r_state   <= CAPTURE;
                    end else begin
                        r_scan_in <= r_pattern[w_cnt - CNT_W'(1)];
                    end
                end
                CAPTURE: begin
                    r_scan_en <= 1'b1;
                    r_scan_in <= 1'b0;
                    r_state   <= SHIFT_OUT;
                end
                SHIFT_OUT: begin
                    r_resp_sh <= w_resp_next;
                    if (w_tc) begin
                        r_scan_en      <= 1'b0;
                        r_done         <= 1'b1;
                        r_response_out <= w_resp_next;
`ifdef SCAN_SEQ_CMP_EN
                        r_pass         <= (w_resp_next == r_expect);
`endif
                        r_state        <= DONE;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_scan_en <= 1'b0;
                    r_scan_in <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.scan_en      = r_scan_en;
    assign bus.scan_in      = r_scan_in;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.response_out = r_response_out;
    assign bus.pass         = r_pass;
endmodule

// File: tb/tb_scan_seq_ctrl.sv
// Directed bench for scan_seq_ctrl with an 8-flop scan chain whose SD is
// tied to ~Q, so every captured response is the bitwise inverse of the load.
module tb_scan_seq_ctrl;
    import scan_seq_pkg::*;

    localparam int N   = 8;
    localparam int LAT = int'(scan_seq_latency(N));

    logic clock   = 1'b0;
    logic reset_l = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    scan_seq_ctrl_if #(.CHAIN_LEN(N)) bus ();

    scan_seq_ctrl #(.CHAIN_LEN(N)) dut (
        .clock   (clock),
        .reset_l (reset_l),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    // Behavioural chain of scanff cells: flop 0 next to SI, SD = ~Q.
    logic [N-1:0] chain = '0;
    always @(posedge clock) begin
        if (bus.scan_en) chain <= {chain[N-2:0], bus.scan_in};
        else             chain <= ~chain;
    end
    assign bus.scan_out = chain[N-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full sequence starting from a negedge in IDLE; ends at the negedge of cycle LAT+1.
    task automatic run_seq(input string tag, input logic [N-1:0] pat, input logic [N-1:0] exp,
                           input bit keep_start, input bit alter);
        logic [LAT:1] se_t, si_t, done_t, busy_t;
        logic [LAT:1] se_e, si_e, done_e;
        logic [N-1:0] resp_done, resp_e;
        logic         pass_done, pass_e;
        logic [2:0]   s_shin, s_cap, s_shout, s_done, s_idle;
        bus.start      = 1'b1;
        bus.pattern_in = pat;
        bus.expect_in  = exp;
        @(posedge clock);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clock);
            se_t[k]   = bus.scan_en;
            si_t[k]   = bus.scan_in;
            done_t[k] = bus.done;
            busy_t[k] = bus.busy;
            if (k == 1)     s_shin  = dut.r_state;
            if (k == N + 1) s_cap   = dut.r_state;
            if (k == N + 2) s_shout = dut.r_state;
            if (k == LAT) begin
                s_done    = dut.r_state;
                resp_done = bus.response_out;
                pass_done = bus.pass;
            end
            if (k == 1 && !keep_start) bus.start = 1'b0;
            if (alter && k == 3) begin
                bus.pattern_in = ~pat;
                bus.expect_in  = ~exp;
            end
        end
        for (int k = 1; k <= LAT; k++) begin
            se_e[k]   = (k <= N) || (k >= N + 2 && k <= 2 * N + 1);
            si_e[k]   = (k <= N) ? pat[N-k] : 1'b0;
            done_e[k] = (k == LAT);
        end
        resp_e = ~pat;
`ifdef SCAN_SEQ_CMP_EN
        pass_e = (resp_e == exp);
`else
        pass_e = 1'b1;
`endif
        check({tag, "_se_trace"},   32'(se_t),   32'(se_e));
        check({tag, "_si_trace"},   32'(si_t),   32'(si_e));
        check({tag, "_done_trace"}, 32'(done_t), 32'(done_e));
        check({tag, "_busy_trace"}, 32'(busy_t), {14'd0, {LAT{1'b1}}});
        check({tag, "_resp"},       32'(resp_done), 32'(resp_e));
        check({tag, "_pass"},       32'(pass_done), 32'(pass_e));
        @(negedge clock);
        s_idle = dut.r_state;
        check({tag, "_states"}, 32'({s_shin, s_cap, s_shout, s_done, s_idle}),
              32'({SCAN_SEQ_ENC_SHIFT_IN, SCAN_SEQ_ENC_CAPTURE, SCAN_SEQ_ENC_SHIFT_OUT,
                   SCAN_SEQ_ENC_DONE, SCAN_SEQ_ENC_IDLE}));
        check({tag, "_busy_after"}, 32'({bus.busy, bus.done}), 32'd0);
        check({tag, "_resp_held"},  32'({bus.response_out, bus.pass}), 32'({resp_e, pass_e}));
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.pattern_in = '0;
        bus.expect_in  = '0;

        // Reset state.
        repeat (2) @(negedge clock);
        check("rst_scan_en",  32'(bus.scan_en), 32'd0);
        check("rst_scan_in",  32'(bus.scan_in), 32'd0);
        check("rst_busy",     32'(bus.busy), 32'd0);
        check("rst_done",     32'(bus.done), 32'd0);
        check("rst_response", 32'(bus.response_out), 32'd0);
        check("rst_pass",     32'(bus.pass), 32'd0);
        check("rst_state",    32'(dut.r_state), 32'(SCAN_SEQ_ENC_IDLE));
        reset_l = 1'b1;

        // No start: stays idle.
        repeat (3) @(negedge clock);
        check("idle_no_start", 32'({bus.busy, bus.scan_en, bus.done}), 32'd0);

        // Basic load/capture/unload, matching and mismatching expectation.
        run_seq("a5",      8'hA5, 8'h5A, 1'b0, 1'b0);
        run_seq("a5_miss", 8'hA5, 8'h5B, 1'b0, 1'b0);

        // start held high: one sequence per accept, re-accept right after done;
        // the second run also changes pattern/expect mid-shift.
        run_seq("held1", 8'h3C, 8'hC3, 1'b1, 1'b0);
        run_seq("held2", 8'h81, 8'h7E, 1'b0, 1'b1);

        // Reset dropped during SHIFT_IN cycle 4.
        bus.start      = 1'b1;
        bus.pattern_in = 8'hF0;
        bus.expect_in  = 8'h0F;
        @(posedge clock);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            bus.start = 1'b0;
        end
        check("mid_state_shift_in", 32'(dut.r_state), 32'(SCAN_SEQ_ENC_SHIFT_IN));
        check("mid_scan_en_pre",    32'(bus.scan_en), 32'd1);
        reset_l = 1'b0;
        #1;
        check("mid_rst_scan_en",  32'(bus.scan_en), 32'd0);
        check("mid_rst_busy",     32'(bus.busy), 32'd0);
        check("mid_rst_response", 32'(bus.response_out), 32'd0);
        check("mid_rst_misc",     32'({bus.scan_in, bus.done, bus.pass}), 32'd0);
        @(negedge clock);
        reset_l = 1'b1;
        @(negedge clock);

        // Fresh sequence after the aborted one.
        run_seq("post_rst", 8'h69, 8'h96, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
